// File: rtl/cdc_fifo_ser_pkg.sv
// Shared types and helpers for the CDC FIFO serializer / deserializer pair.
package cdc_fifo_ser_pkg;

   // Beat width used when the instantiating code does not override it.
   localparam int unsigned DEFAULT_BEAT_WIDTH = 8;

   typedef enum logic {
      SER_IDLE = 1'b0,
      SER_SEND = 1'b1
   } ser_state_e;

   // Limits a requested beat count (minus one) to the last beat index of a word.
   // Only matters when the beat count is not a power of two.
   function automatic int unsigned clamp_len(input int unsigned len,
                                             input int unsigned max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/cdc_fifo_ser_beat_mux.sv
// Combinational beat select: picks beat cnt_i out of a wide word, LSB beat = index 0.
module cdc_fifo_ser_beat_mux #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BEAT_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 2
) (
   input  logic [DATA_WIDTH-1:0] word_i,
   input  logic [CNT_WIDTH-1:0]  cnt_i,
   output logic [BEAT_WIDTH-1:0] beat_o
);

   localparam int unsigned NUM_BEATS = DATA_WIDTH / BEAT_WIDTH;

   // One-hot compare per beat slot; out-of-range indices select zero.
   always_comb begin
      beat_o = '0;
      for (int i = 0; i < NUM_BEATS; i++) begin
         if (cnt_i == CNT_WIDTH'(i)) begin
            beat_o = word_i[i*BEAT_WIDTH +: BEAT_WIDTH];
         end
      end
   end

endmodule

// File: rtl/cdc_fifo_src_serializer.sv
// Source-side serializer feeding the CDC FIFO write port: splits each wide word
// into narrow beats, LSB beat first, with a last flag on the final beat.
// Optional build macro CDC_FIFO_SER_PARITY_EN adds out_par_o (even parity of out_data_o).
//
// Handshakes: both sides use valid/ready. A transfer happens on a cycle where
// valid and ready are both high; once out_valid_o is high it stays high with
// out_data_o/out_last_o stable until out_ready_i accepts the beat. in_ready_o may
// depend combinationally on out_ready_i (word hand-over on the last beat).
module cdc_fifo_src_serializer
   import cdc_fifo_ser_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BEAT_WIDTH = DEFAULT_BEAT_WIDTH,
   localparam int unsigned NUM_BEATS = DATA_WIDTH / BEAT_WIDTH,
   localparam int unsigned CNT_WIDTH = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
   input  logic                  src_clk_i,
   input  logic                  src_rst_ni,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic [CNT_WIDTH-1:0]  in_len_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [BEAT_WIDTH-1:0] out_data_o,
   output logic                  out_last_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic                  busy_o
`ifdef CDC_FIFO_SER_PARITY_EN
   ,
   output logic                  out_par_o
`endif
);

   ser_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]  len_q, len_d;
   logic [BEAT_WIDTH-1:0] beat_sel;
   logic                  is_last;

   // Length captured with the word, clamped so the counter can never pass the last slot.
   logic [CNT_WIDTH-1:0]  len_clamped;
   assign len_clamped = CNT_WIDTH'(clamp_len(int'(in_len_i), NUM_BEATS - 1));

   cdc_fifo_ser_beat_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .BEAT_WIDTH (BEAT_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_beat_mux (
      .word_i (word_q),
      .cnt_i  (cnt_q),
      .beat_o (beat_sel)
   );

   assign is_last = (cnt_q == len_q);

   // Next-state, counter and handshake outputs; a finishing word may hand over
   // directly to the next one so back-to-back words leave no bubble.
   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      out_last_o  = 1'b0;
      out_data_o  = '0;
      busy_o      = 1'b0;

      unique case (state_q)
         SER_IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               word_d  = in_data_i;
               len_d   = len_clamped;
               cnt_d   = '0;
               state_d = SER_SEND;
            end
         end

         SER_SEND: begin
            busy_o      = 1'b1;
            out_valid_o = 1'b1;
            out_last_o  = is_last;
            out_data_o  = beat_sel;
            if (out_ready_i) begin
               if (!is_last) begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end else begin
                  in_ready_o = 1'b1;
                  if (in_valid_i) begin
                     word_d = in_data_i;
                     len_d  = len_clamped;
                     cnt_d  = '0;
                  end else begin
                     state_d = SER_IDLE;
                  end
               end
            end
         end

         default: state_d = SER_IDLE;
      endcase
   end

   // State, word, length and beat counter registers; reset drops any held word.
   always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
      if (!src_rst_ni) begin
         state_q <= SER_IDLE;
         word_q  <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end

`ifdef CDC_FIFO_SER_PARITY_EN
   // Parity derives only from registered word/counter, so it moves with the beat.
   assign out_par_o = ^out_data_o;
`endif

endmodule

// File: tb/tb_cdc_fifo_src_serializer.sv
// Directed bench for cdc_fifo_src_serializer: per-cycle vector table plus a
// hand-written mid-word reset sequence.
module tb_cdc_fifo_src_serializer;

  localparam int DW = 32;
  localparam int BW = 8;
  localparam int CW = 2;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_len;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
`ifdef CDC_FIFO_SER_PARITY_EN
  logic          out_par;
`endif

  int n_checks = 0;
  int n_errors = 0;

  cdc_fifo_src_serializer #(
    .DATA_WIDTH (DW),
    .BEAT_WIDTH (BW)
  ) dut (
    .src_clk_i   (clk),
    .src_rst_ni  (rst_n),
    .in_data_i   (in_data),
    .in_len_i    (in_len),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .busy_o      (busy)
`ifdef CDC_FIFO_SER_PARITY_EN
    ,
    .out_par_o   (out_par)
`endif
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic [CW-1:0] il;
    logic          ordy;
    logic          e_valid;
    logic [BW-1:0] e_data;
    logic          e_last;
    logic          e_in_ready;
    logic          e_busy;
  } vec_t;

  vec_t vec_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] il,
                     input logic ordy, input logic ev, input logic [BW-1:0] ed,
                     input logic el, input logic eir, input logic eb);
    vec_t v;
    v.iv = iv; v.id = id; v.il = il; v.ordy = ordy;
    v.e_valid = ev; v.e_data = ed; v.e_last = el; v.e_in_ready = eir; v.e_busy = eb;
    vec_q.push_back(v);
  endtask

  task automatic drive(input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] il,
                       input logic ordy);
    in_valid  = iv;
    in_data   = id;
    in_len    = il;
    out_ready = ordy;
  endtask

  task automatic check_beat(input string tag, input logic [BW-1:0] ed, input logic el);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " data"}, 32'(out_data), 32'(ed));
    check({tag, " last"}, 32'(out_last), 32'(el));
`ifdef CDC_FIFO_SER_PARITY_EN
    check({tag, " par"}, 32'(out_par), 32'(^ed));
`endif
  endtask

  initial begin
    string tag;
    // reset
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst last", 32'(out_last), 32'd0);
    check("rst data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //  iv    data           len  ordy  ev    edata  elast  in_rdy busy
    // idle
    add(1'b0, 32'h0,         2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    // full word, no backpressure
    add(1'b1, 32'hDDCCBBAA, 2'd3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    add(1'b0, 32'h0,         2'd0, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    add(1'b0, 32'h0,         2'd0, 1'b1, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
    add(1'b0, 32'h0,         2'd0, 1'b1, 1'b1, 8'hCC, 1'b0, 1'b0, 1'b1);
    add(1'b0, 32'h0,         2'd0, 1'b1, 1'b1, 8'hDD, 1'b1, 1'b1, 1'b1);
    // back-to-back, in_valid held
    add(1'b1, 32'h44332211, 2'd3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    add(1'b1, 32'h88776655, 2'd3, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    add(1'b1, 32'h88776655, 2'd3, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    add(1'b1, 32'h88776655, 2'd3, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
    add(1'b1, 32'h88776655, 2'd3, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1);
    add(1'b0, 32'h0,         2'd0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    add(1'b0, 32'h0,         2'd0, 1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 1'b1);
    add(1'b0, 32'h0,         2'd0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    add(1'b0, 32'h0,         2'd0, 1'b1, 1'b1, 8'h88, 1'b1, 1'b1, 1'b1);
    // backpressure on beat 2 for 5 cycles
    add(1'b1, 32'hDDCCBBAA, 2'd3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    add(1'b0, 32'h0,         2'd0, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    add(1'b0, 32'h0,         2'd0, 1'b1, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      add(1'b0, 32'h0,       2'd0, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b0, 1'b1);
    add(1'b0, 32'h0,         2'd0, 1'b1, 1'b1, 8'hCC, 1'b0, 1'b0, 1'b1);
    add(1'b0, 32'h0,         2'd0, 1'b1, 1'b1, 8'hDD, 1'b1, 1'b1, 1'b1);
    // partial word, single beat
    add(1'b1, 32'h000000EF, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    add(1'b0, 32'h0,         2'd0, 1'b1, 1'b1, 8'hEF, 1'b1, 1'b1, 1'b1);
    add(1'b0, 32'h0,         2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    // two-beat word, stall on the last beat: no hand-over while stalled
    add(1'b1, 32'h00001234, 2'd1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    add(1'b1, 32'h000000AB, 2'd0, 1'b1, 1'b1, 8'h34, 1'b0, 1'b0, 1'b1);
    add(1'b1, 32'h000000AB, 2'd0, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 1'b1);
    add(1'b1, 32'h000000AB, 2'd0, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 1'b1);
    add(1'b1, 32'h000000AB, 2'd0, 1'b1, 1'b1, 8'h12, 1'b1, 1'b1, 1'b1);
    add(1'b0, 32'h0,         2'd0, 1'b1, 1'b1, 8'hAB, 1'b1, 1'b1, 1'b1);
    add(1'b0, 32'h0,         2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    foreach (vec_q[k]) begin
      @(negedge clk);
      drive(vec_q[k].iv, vec_q[k].id, vec_q[k].il, vec_q[k].ordy);
      #1;
      tag = $sformatf("v%0d", k);
      check({tag, " valid"}, 32'(out_valid), 32'(vec_q[k].e_valid));
      check({tag, " in_ready"}, 32'(in_ready), 32'(vec_q[k].e_in_ready));
      check({tag, " busy"}, 32'(busy), 32'(vec_q[k].e_busy));
      if (vec_q[k].e_valid) begin
        check({tag, " data"}, 32'(out_data), 32'(vec_q[k].e_data));
        check({tag, " last"}, 32'(out_last), 32'(vec_q[k].e_last));
`ifdef CDC_FIFO_SER_PARITY_EN
        check({tag, " par"}, 32'(out_par), 32'(^vec_q[k].e_data));
`endif
      end
    end

    // reset in the middle of a word
    @(negedge clk);
    drive(1'b1, 32'h11223344, 2'd3, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b1);
    #1 check_beat("mr b0", 8'h44, 1'b0);
    @(negedge clk);
    #1 check_beat("mr b1", 8'h33, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mr rst valid", 32'(out_valid), 32'd0);
    check("mr rst busy", 32'(busy), 32'd0);
    check("mr rst in_ready", 32'(in_ready), 32'd1);
    check("mr rst data", 32'(out_data), 32'd0);
    check("mr rst last", 32'(out_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 32'h0A090807, 2'd3, 1'b1);
    #1 check("mr idle ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b1);
    #1 check_beat("mr n0", 8'h07, 1'b0);
`ifdef CDC_FIFO_SER_PARITY_EN
    check("mr par 07", 32'(out_par), 32'd1);
`endif
    @(negedge clk);
    #1 check_beat("mr n1", 8'h08, 1'b0);
    @(negedge clk);
    #1 check_beat("mr n2", 8'h09, 1'b0);
    @(negedge clk);
    #1 check_beat("mr n3", 8'h0A, 1'b1);
    @(negedge clk);
    #1 check("mr end valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
